// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, size encoding and defaults for the byte-wide RAM arbiter
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DONE
  } state_t;

  localparam logic [1:0]  SZ_BYTE         = 2'b00;
  localparam logic [1:0]  SZ_HALF         = 2'b01;
  localparam logic [1:0]  SZ_WORD         = 2'b10;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // The reserved 2'b11 encoding is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_byte_asm.sv
// rtl/mem_arb_byte_asm.sv - byte counter, address stepping, read assembly and write byte select
module mem_arb_byte_asm
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              capture,
  input  logic              hold,
  input  logic [ADDR_W-1:0] base_in,
  input  logic [31:0]       load_in,
  input  logic [7:0]        ram_din,
  output logic [2:0]        cnt,
  output logic [2:0]        idx,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        wbyte,
  output logic [31:0]       data_nxt
);

  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        slot;

  // Byte arriving now belongs to the address issued one count earlier.
  assign slot = cnt_q[1:0] - 2'd1;

  always_comb begin
    cnt_d  = cnt_q;
    base_d = base_q;
    data_d = data_q;
    if (start) begin
      cnt_d  = 3'd0;
      base_d = base_in;
      data_d = load_in;
    end else if (step) begin
      cnt_d = cnt_q + 3'd1;
      if (capture && cnt_q != 3'd0) begin
        data_d[{slot, 3'b000} +: 8] = ram_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 3'd0;
      base_q <= '0;
      data_q <= 32'h0;
    end else begin
      cnt_q  <= cnt_d;
      base_q <= base_d;
      data_q <= data_d;
    end
  end

  // While frozen, re-present the previous address so ram_din still holds the
  // byte that is owed on the first cycle after resuming.
  assign idx      = (hold && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;
  assign addr     = base_q + {{(ADDR_W-3){1'b0}}, idx};
  assign cnt      = cnt_q;
  assign wbyte    = data_q[{cnt_q[1:0], 3'b000} +: 8];
  assign data_nxt = data_d;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM arbiter onto a byte-wide RAM port; MEM_ARB_IO_STALL_EN holds IO stores while the IO buffer is full
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_clear,
  output logic [31:0]       if_data,
  output logic              if_rdy,
  output logic              if_busy,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_rdy,
  output logic              mem_busy,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  state_t            state_q, state_d;
  logic              fair_q, fair_d;
  logic              if_src_q, if_src_d;
  logic [2:0]        n_q, n_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic              start, step, capture;
  logic [ADDR_W-1:0] base_in, asm_addr;
  logic [31:0]       load_in, asm_nxt;
  logic [2:0]        cnt, idx;
  logic [7:0]        wbyte;
  logic              io_stall, mem_ok, if_ok, grant_mem, a_valid;

`ifdef MEM_ARB_IO_STALL_EN
  assign io_stall = mem_we && io_buffer_full && (mem_addr >= ADDR_W'(IO_BASE));
`else
  logic unused_io;
  assign unused_io = io_buffer_full ^ IO_BASE[0];
  assign io_stall  = 1'b0;
`endif

  assign mem_ok    = mem_req && !io_stall;
  assign if_ok     = if_req && !if_clear;
  assign grant_mem = mem_ok && (!if_ok || !fair_q);

  always_comb begin
    state_d     = state_q;
    fair_d      = fair_q;
    if_src_d    = if_src_q;
    n_d         = n_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    start       = 1'b0;
    step        = 1'b0;
    capture     = 1'b0;
    base_in     = mem_addr;
    load_in     = 32'h0;
    if (rdy_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_mem) begin
            start    = 1'b1;
            load_in  = mem_we ? mem_wdata : 32'h0;
            n_d      = size_bytes(mem_size);
            state_d  = mem_we ? ST_MEM_WR : ST_MEM_RD;
            fair_d   = 1'b1;
            if_src_d = 1'b0;
          end else if (if_ok) begin
            start    = 1'b1;
            base_in  = if_addr;
            n_d      = 3'd4;
            state_d  = ST_IF_RD;
            fair_d   = 1'b0;
            if_src_d = 1'b1;
          end
        end
        ST_IF_RD: begin
          if (if_clear) begin
            state_d = ST_IDLE;
          end else begin
            step    = 1'b1;
            capture = 1'b1;
            if (cnt == n_q) begin
              state_d   = ST_DONE;
              if_data_d = asm_nxt;
            end
          end
        end
        ST_MEM_RD: begin
          step    = 1'b1;
          capture = 1'b1;
          if (cnt == n_q) begin
            state_d     = ST_DONE;
            mem_rdata_d = asm_nxt;
          end
        end
        ST_MEM_WR: begin
          step = 1'b1;
          if (cnt == n_q - 3'd1) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fair_q      <= 1'b0;
      if_src_q    <= 1'b0;
      n_q         <= 3'd0;
      if_data_q   <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      fair_q      <= fair_d;
      if_src_q    <= if_src_d;
      n_q         <= n_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  mem_arb_byte_asm #(.ADDR_W(ADDR_W)) u_byte_asm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step     (step),
    .capture  (capture),
    .hold     (!rdy_in),
    .base_in  (base_in),
    .load_in  (load_in),
    .ram_din  (ram_din),
    .cnt      (cnt),
    .idx      (idx),
    .addr     (asm_addr),
    .wbyte    (wbyte),
    .data_nxt (asm_nxt)
  );

  // Reads spend one extra cycle collecting the last byte with no address issued.
  assign a_valid   = ((state_q == ST_IF_RD || state_q == ST_MEM_RD) && idx < n_q)
                   || state_q == ST_MEM_WR;
  assign ram_a     = a_valid ? asm_addr : '0;
  assign ram_wr    = (state_q == ST_MEM_WR) && rdy_in;
  assign ram_dout  = (state_q == ST_MEM_WR) ? wbyte : 8'h00;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign if_rdy    = (state_q == ST_DONE) && if_src_q && rdy_in;
  assign mem_rdy   = (state_q == ST_DONE) && !if_src_q && rdy_in;
  assign if_busy   = (state_q == ST_IF_RD) || (state_q == ST_DONE && if_src_q);
  assign mem_busy  = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR)
                   || (state_q == ST_DONE && !if_src_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a 1-cycle-latency RAM model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy_in;
  logic        if_req, if_clear, if_rdy, if_busy;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_we, mem_rdy, mem_busy;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, io_buffer_full;

  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;
  logic [7:0]  ram [0:4095];

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_data(if_data), .if_rdy(if_rdy), .if_busy(if_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_rdy(mem_rdy), .mem_busy(mem_busy),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    nxt;
    pre_we = 1'b0;
  endtask

  task automatic wait_rdy(input bit on_mem, output int cyc);
    cyc = 0;
    do begin
      nxt; #1;
      cyc++;
    end while (!(on_mem ? mem_rdy : if_rdy) && cyc < 20);
  endtask

  initial begin
    rst = 1'b1; rdy_in = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    if_req = 0; if_addr = 0; if_clear = 0;
    mem_req = 0; mem_we = 0; mem_size = 0; mem_addr = 0; mem_wdata = 0;
    io_buffer_full = 0;
    nxt; nxt;
    preload(12'h100, 8'h13); preload(12'h101, 8'h05);
    preload(12'h102, 8'h00); preload(12'h103, 8'h00);
    preload(12'h300, 8'hA5);
    preload(12'h400, 8'h11); preload(12'h401, 8'h22);
    preload(12'h402, 8'h33); preload(12'h403, 8'h44);
    #1;
    check("rst_if_data", if_data, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_busy", 32'({if_busy, mem_busy}), 32'h0);
    check("rst_ram", 32'({ram_wr, if_rdy, mem_rdy}), 32'h0);
    check("rst_ram_a", ram_a, 32'h0);
    rst = 1'b0;
    nxt;

    // IF word read @0x100
    if_req = 1; if_addr = 32'h100; #1;
    nxt; #1; check("if_busy", 32'(if_busy), 1); check("if_a0", ram_a, 32'h100);
    nxt; #1; check("if_a1", ram_a, 32'h101);
    nxt; #1; check("if_a2", ram_a, 32'h102);
    nxt; #1; check("if_a3", ram_a, 32'h103); check("if_wr", 32'(ram_wr), 0);
    nxt; #1; check("if_rdy_early", 32'(if_rdy), 0);
    nxt; #1; check("if_rdy_t6", 32'(if_rdy), 1); check("if_data", if_data, 32'h0000_0513);
    if_req = 0;
    nxt; #1; check("if_rdy_pulse", 32'(if_rdy), 0); check("if_idle_busy", 32'(if_busy), 0);

    // simultaneous requests: MEM first, then IF despite mem_req reasserted
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_size = 2'b00; mem_addr = 32'h300; #1;
    nxt; #1; check("both_mem_busy", 32'({mem_busy, if_busy}), 32'h2); check("both_a", ram_a, 32'h300);
    nxt; #1; check("both_rdy_early", 32'(mem_rdy), 0);
    nxt; #1; check("both_mem_rdy", 32'(mem_rdy), 1); check("both_rdata", mem_rdata, 32'h0000_00A5);
    mem_req = 0;
    nxt; mem_req = 1; mem_addr = 32'h403; #1;
    nxt; #1; check("fair_if_busy", 32'({mem_busy, if_busy}), 32'h1);
    wait_rdy(1'b0, n); check("fair_if_lat", n, 5); check("fair_if_data", if_data, 32'h0000_0513);
    if_req = 0;
    wait_rdy(1'b1, n); check("fair_mem_lat", n, 4); check("fair_mem_rdata", mem_rdata, 32'h44);
    mem_req = 0;
    nxt;

    // if_clear in second byte cycle, pending MEM load follows
    if_req = 1; mem_req = 1; mem_addr = 32'h402; #1;
    nxt; #1; check("clr_if_busy", 32'(if_busy), 1);
    nxt; if_clear = 1; #1;
    nxt; if_clear = 0; if_req = 0; #1;
    check("clr_idle", 32'({if_busy, mem_busy, if_rdy}), 0);
    wait_rdy(1'b1, n); check("clr_mem_lat", n, 3); check("clr_rdata", mem_rdata, 32'h33);
    check("clr_if_data_kept", if_data, 32'h0000_0513);
    mem_req = 0;
    nxt;

    // store half 0xBEEF @0x200, then read it back
    mem_req = 1; mem_we = 1; mem_size = 2'b01; mem_addr = 32'h200; mem_wdata = 32'h0000_BEEF; #1;
    nxt; #1; check("st_c1", {23'h0, ram_wr, ram_dout}, 32'h1EF); check("st_a0", ram_a, 32'h200);
    nxt; #1; check("st_c2", {23'h0, ram_wr, ram_dout}, 32'h1BE); check("st_a1", ram_a, 32'h201);
    nxt; #1; check("st_rdy", 32'({mem_rdy, ram_wr}), 32'h2);
    mem_req = 0;
    nxt; mem_req = 1; mem_we = 0; #1;
    wait_rdy(1'b1, n); check("ld_half_lat", n, 4); check("ld_half", mem_rdata, 32'h0000_BEEF);
    mem_req = 0;
    nxt;

    // word load with 3 frozen cycles
    mem_req = 1; mem_we = 0; mem_size = 2'b10; mem_addr = 32'h400; #1;
    nxt; nxt;
    nxt; rdy_in = 0; #1; check("frz_wr", 32'({ram_wr, mem_rdy}), 0);
    nxt; nxt; check("frz_busy", 32'(mem_busy), 1);
    nxt; rdy_in = 1; #1;
    wait_rdy(1'b1, n); check("frz_lat", n, 3); check("frz_data", mem_rdata, 32'h4433_2211);
    mem_req = 0;
    nxt;

    // store byte frozen in its first write cycle
    mem_req = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h210; mem_wdata = 32'h55; #1;
    nxt; rdy_in = 0; #1; check("frz_st_wr", 32'({ram_wr, mem_busy}), 32'h1);
    nxt; rdy_in = 1; #1; check("frz_st_go", {23'h0, ram_wr, ram_dout}, 32'h155); check("frz_st_a", ram_a, 32'h210);
    nxt; #1; check("frz_st_rdy", 32'(mem_rdy), 1);
    mem_req = 0;
    nxt;

    // IO store with buffer full
    mem_req = 1; mem_we = 1; mem_size = 2'b00; mem_addr = 32'h30004; mem_wdata = 32'h5A;
    io_buffer_full = 1; #1;
`ifdef MEM_ARB_IO_STALL_EN
    nxt; #1; check("io_stall1", 32'({ram_wr, mem_busy}), 0);
    nxt; #1; check("io_stall2", 32'({ram_wr, mem_busy}), 0);
    io_buffer_full = 0;
    nxt; #1; check("io_go", {23'h0, ram_wr, ram_dout}, 32'h15A); check("io_a", ram_a, 32'h30004);
    nxt; #1; check("io_rdy", 32'(mem_rdy), 1);
`else
    nxt; #1; check("io_go", {23'h0, ram_wr, ram_dout}, 32'h15A); check("io_a", ram_a, 32'h30004);
    nxt; #1; check("io_rdy", 32'(mem_rdy), 1);
`endif
    mem_req = 0; io_buffer_full = 0;
    nxt;

    // reset mid IF read
    if_req = 1; if_addr = 32'h100; #1;
    nxt; nxt; rst = 1; #1;
    nxt; #1; check("rst_mid", 32'({if_busy, if_rdy, mem_busy}), 0); check("rst_mid_a", ram_a, 32'h0);
    rst = 0; if_req = 0;
    nxt;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
